// File: rtl/nibble_serial_adder_if.sv
// Operand/result bundle for nibble_serial_adder.
// Optional overflow flag V is present only when NIBBLE_SERIAL_OVERFLOW_EN is defined.
interface nibble_serial_adder_if #(
  parameter int W = 16
);
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         busy;
  logic         done;
  logic [W-1:0] S;
  logic         Cout;
`ifdef NIBBLE_SERIAL_OVERFLOW_EN
  logic         V;

  modport master (output start, A, B, Cin, input busy, done, S, Cout, V);
  modport slave  (input start, A, B, Cin, output busy, done, S, Cout, V);
`else
  modport master (output start, A, B, Cin, input busy, done, S, Cout);
  modport slave  (input start, A, B, Cin, output busy, done, S, Cout);
`endif
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-cycle W-bit adder (W = 4*NIBBLES): one nibble per clock, LSB nibble first,
// each nibble through a 4-bit carry-lookahead stage, carry chained via a register.
// Optional feature macro: NIBBLE_SERIAL_OVERFLOW_EN (adds signed-overflow output V).
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input logic            clk,
  input logic            rst,
  nibble_serial_adder_if.slave bus
);
  localparam int W     = 4 * NIBBLES;
  // A single-nibble build still needs a 1-bit index to keep widths legal.
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [W-1:0]     a_reg, b_reg;     // operands, shifted right one nibble per RUN cycle
  logic [W-1:0]     s_reg;
  logic [W-1:0]     s_next;
  logic [IDX_W-1:0] idx_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             busy, done, accept, last;

  logic [3:0]       a_nib, b_nib, g, p, sum;
  logic [4:0]       c;

  assign a_nib = a_reg[3:0];
  assign b_nib = b_reg[3:0];
  assign last  = (idx_reg == IDX_W'(NIBBLES - 1));

  // 4-bit look-ahead stage: every carry is formed directly from generate/propagate terms.
  always_comb begin
    g    = a_nib & b_nib;
    p    = a_nib ^ b_nib;
    c[0] = carry_reg;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    sum  = p ^ c[3:0];
  end

  // Only the nibble selected by the index is overwritten; the rest of S holds.
  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_swr
      assign s_next[4*gi +: 4] = (idx_reg == IDX_W'(gi)) ? sum : s_reg[4*gi +: 4];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and status decode; start is only honoured in IDLE or DONE.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture on accept, one nibble per RUN cycle, final carry on the last nibble.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
      idx_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
    end else if (accept) begin
      a_reg     <= bus.A;
      b_reg     <= bus.B;
      s_reg     <= '0;
      idx_reg   <= '0;
      carry_reg <= bus.Cin;
      cout_reg  <= 1'b0;
    end else if (state_reg == RUN) begin
      a_reg     <= a_reg >> 4;
      b_reg     <= b_reg >> 4;
      s_reg     <= s_next;
      carry_reg <= c[4];
      if (last) cout_reg <= c[4];
      else      idx_reg  <= idx_reg + IDX_W'(1);
    end
  end

`ifdef NIBBLE_SERIAL_OVERFLOW_EN
  logic v_reg;

  // Signed overflow = carry into the top bit XOR carry out, taken on the last nibble.
  always_ff @(posedge clk) begin
    if (rst)                              v_reg <= 1'b0;
    else if (accept)                      v_reg <= 1'b0;
    else if ((state_reg == RUN) && last)  v_reg <= c[3] ^ c[4];
  end

  assign bus.V = v_reg;
`endif

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.S    = s_reg;
  assign bus.Cout = cout_reg;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed steps on a 4-nibble instance,
// then random operands on 1-, 4- and 5-nibble instances against a reference sum.
module tb_nibble_serial_adder;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_if #(.W(4))  i1 ();
  nibble_serial_adder_if #(.W(16)) i4 ();
  nibble_serial_adder_if #(.W(20)) i5 ();

  nibble_serial_adder #(.NIBBLES(1)) u1 (.clk(clk), .rst(rst), .bus(i1));
  nibble_serial_adder #(.NIBBLES(4)) u4 (.clk(clk), .rst(rst), .bus(i4));
  nibble_serial_adder #(.NIBBLES(5)) u5 (.clk(clk), .rst(rst), .bus(i5));

  typedef struct {
    logic [19:0] s;
    logic        c;
    logic        v;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  exp_t q5[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: w-bit unsigned sum with carry, plus signed overflow from operand/result signs.
  function automatic exp_t make_exp(input logic [19:0] a, input logic [19:0] b,
                                    input logic cin, input int w);
    logic [20:0] mask;
    logic [20:0] full;
    exp_t        e;
    mask = (21'd1 << w) - 21'd1;
    full = ({1'b0, a} & mask) + ({1'b0, b} & mask) + 21'(cin);
    e.s  = full[19:0] & mask[19:0];
    e.c  = full[w];
    e.v  = (a[w-1] == b[w-1]) && (full[w-1] != a[w-1]);
    return e;
  endfunction

  // Waits (bounded) for done on the 4-nibble instance, then pops and checks the result.
  task automatic wait_done4(input string tag);
    int   k;
    exp_t e;
    k = 0;
    while (i4.done !== 1'b1 && k < 12) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done"}, 32'(i4.done), 32'd1);
    if (i4.done === 1'b1 && q4.size() > 0) begin
      e = q4.pop_front();
      chk({tag, "_busy_at_done"}, 32'(i4.busy), 32'd0);
      chk({tag, "_S"}, 32'(i4.S), 32'(e.s));
      chk({tag, "_Cout"}, 32'(i4.Cout), 32'(e.c));
`ifdef NIBBLE_SERIAL_OVERFLOW_EN
      chk({tag, "_V"}, 32'(i4.V), 32'(e.v));
`endif
      $display("txn %s S=%h Cout=%b", tag, i4.S, i4.Cout);
    end
  endtask

  // One add on the 4-nibble instance with exact busy/done timing checks.
  task automatic add4(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic cin);
    q4.push_back(make_exp({4'h0, a}, {4'h0, b}, cin, 16));
    @(negedge clk);
    i4.start = 1'b1; i4.A = a; i4.B = b; i4.Cin = cin;
    @(negedge clk);
    i4.start = 1'b0; i4.A = 16'($urandom); i4.B = 16'($urandom); i4.Cin = 1'($urandom);
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_busy"}, 32'(i4.busy), 32'd1);
      chk({tag, "_early_done"}, 32'(i4.done), 32'd0);
      @(negedge clk);
    end
    chk({tag, "_done_on_time"}, 32'(i4.done), 32'd1);
    wait_done4(tag);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(i4.done), 32'd0);
  endtask

  // Same random operands into all three widths; each result popped when its done appears.
  task automatic run3(input int n, input logic [19:0] a, input logic [19:0] b, input logic cin);
    exp_t e;
    bit   g1, g4, g5;
    q1.push_back(make_exp(a, b, cin, 4));
    q4.push_back(make_exp(a, b, cin, 16));
    q5.push_back(make_exp(a, b, cin, 20));
    @(negedge clk);
    i1.A = a[3:0];  i1.B = b[3:0];  i1.Cin = cin; i1.start = 1'b1;
    i4.A = a[15:0]; i4.B = b[15:0]; i4.Cin = cin; i4.start = 1'b1;
    i5.A = a;       i5.B = b;       i5.Cin = cin; i5.start = 1'b1;
    @(negedge clk);
    i1.start = 1'b0; i4.start = 1'b0; i5.start = 1'b0;
    g1 = 1'b0; g4 = 1'b0; g5 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (i1.done === 1'b1) begin
        if (q1.size() == 0) chk("r1_extra_done", 32'(i1.done), 32'd0);
        else begin
          g1 = 1'b1; e = q1.pop_front();
          chk("r1_S", 32'(i1.S), 32'(e.s));
          chk("r1_Cout", 32'(i1.Cout), 32'(e.c));
`ifdef NIBBLE_SERIAL_OVERFLOW_EN
          chk("r1_V", 32'(i1.V), 32'(e.v));
`endif
        end
      end
      if (i4.done === 1'b1) begin
        if (q4.size() == 0) chk("r4_extra_done", 32'(i4.done), 32'd0);
        else begin
          g4 = 1'b1; e = q4.pop_front();
          chk("r4_S", 32'(i4.S), 32'(e.s));
          chk("r4_Cout", 32'(i4.Cout), 32'(e.c));
`ifdef NIBBLE_SERIAL_OVERFLOW_EN
          chk("r4_V", 32'(i4.V), 32'(e.v));
`endif
        end
      end
      if (i5.done === 1'b1) begin
        if (q5.size() == 0) chk("r5_extra_done", 32'(i5.done), 32'd0);
        else begin
          g5 = 1'b1; e = q5.pop_front();
          chk("r5_S", 32'(i5.S), 32'(e.s));
          chk("r5_Cout", 32'(i5.Cout), 32'(e.c));
`ifdef NIBBLE_SERIAL_OVERFLOW_EN
          chk("r5_V", 32'(i5.V), 32'(e.v));
`endif
        end
      end
      @(negedge clk);
    end
    chk("r1_got", 32'(g1), 32'd1);
    chk("r4_got", 32'(g4), 32'd1);
    chk("r5_got", 32'(g5), 32'd1);
    $display("txn rnd%0d A=%h B=%h Cin=%b S5=%h Cout5=%b", n, a, b, cin, i5.S, i5.Cout);
  endtask

  initial begin
    rst = 1'b1;
    i1.start = 1'b0; i1.A = '0; i1.B = '0; i1.Cin = 1'b0;
    i4.start = 1'b0; i4.A = '0; i4.B = '0; i4.Cin = 1'b0;
    i5.start = 1'b0; i5.A = '0; i5.B = '0; i5.Cin = 1'b0;

    // Step 1: reset, then idle with start low.
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(i4.busy), 32'd0);
    chk("rst_done", 32'(i4.done), 32'd0);
    chk("rst_S", 32'(i4.S), 32'd0);
    chk("rst_Cout", 32'(i4.Cout), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_busy", 32'(i4.busy), 32'd0);
      chk("idle_done", 32'(i4.done), 32'd0);
      chk("idle_S", 32'(i4.S), 32'd0);
    end

    // Steps 2-3: basic adds with carry propagation and Cin.
    add4("carry8", 16'h00FF, 16'h0001, 1'b0);
    add4("wrap", 16'hFFFF, 16'h0001, 1'b0);
    add4("cin_only", 16'h0000, 16'h0000, 1'b1);

    // Step 4a: start during RUN with different operands is ignored.
    q4.push_back(make_exp(20'h01234, 20'h01111, 1'b0, 16));
    @(negedge clk);
    i4.start = 1'b1; i4.A = 16'h1234; i4.B = 16'h1111; i4.Cin = 1'b0;
    @(negedge clk);
    i4.A = 16'hFFFF; i4.B = 16'hFFFF; i4.Cin = 1'b1;
    @(negedge clk);
    i4.start = 1'b0;
    wait_done4("ignore_run_start");

    // Step 4b: start held through done gives back-to-back adds.
    @(negedge clk);
    q4.push_back(make_exp(20'h1, 20'h2, 1'b0, 16));
    i4.start = 1'b1; i4.A = 16'h0001; i4.B = 16'h0002; i4.Cin = 1'b0;
    wait_done4("b2b_first");
    q4.push_back(make_exp(20'h3, 20'h4, 1'b0, 16));
    i4.A = 16'h0003; i4.B = 16'h0004;
    @(negedge clk);
    chk("b2b_no_idle_busy", 32'(i4.busy), 32'd1);
    chk("b2b_no_idle_done", 32'(i4.done), 32'd0);
    i4.start = 1'b0;
    wait_done4("b2b_second");

    // Step 5: reset at edge E+2 aborts the add without a done.
    @(negedge clk);
    i4.start = 1'b1; i4.A = 16'h1234; i4.B = 16'h5678; i4.Cin = 1'b0;
    @(negedge clk);
    i4.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(i4.busy), 32'd0);
    chk("abort_S", 32'(i4.S), 32'd0);
    chk("abort_done", 32'(i4.done), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(i4.done), 32'd0);
    end
    add4("after_abort", 16'hABCD, 16'h1111, 1'b1);

    // Step 6: signed-overflow corners (V checked when the feature is built in).
    add4("ovf_pos", 16'h7FFF, 16'h0001, 1'b0);
    add4("ovf_neg", 16'h8000, 16'h8000, 1'b0);
    add4("no_ovf", 16'h0003, 16'h0004, 1'b0);

    // Random operands across 1, 4 and 5 nibbles.
    for (int n = 0; n < 1000; n++) begin
      run3(n, 20'($urandom), 20'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
